// File: rtl/platform_scroll_gen_if.sv
// -----------------------------------------------------------------------------
// platform_scroll_gen_if
// Bundles the frame-timing input, the scroll request handshake and the
// platform row window that platform_scroll_gen drives toward VGA_Logic.
//
//   vsync           active-low vertical sync from VGA_Logic
//   scroll_req      scroll request, sampled every clock
//   scroll_ack      one-cycle pulse: request accepted
//   scrolling       high while the scroller is not idle
//   plataform_start first platform row
//   plataform_end   last platform row
//
// Modports:
//   master - the requester / timing side (drives vsync and scroll_req)
//   slave  - the scroll generator (drives ack, status and the row window)
// -----------------------------------------------------------------------------
interface platform_scroll_gen_if;
  logic       vsync;
  logic       scroll_req;
  logic       scroll_ack;
  logic       scrolling;
  logic [9:0] plataform_start;
  logic [9:0] plataform_end;

  modport master (
    output vsync,
    output scroll_req,
    input  scroll_ack,
    input  scrolling,
    input  plataform_start,
    input  plataform_end
  );

  modport slave (
    input  vsync,
    input  scroll_req,
    output scroll_ack,
    output scrolling,
    output plataform_start,
    output plataform_end
  );
endinterface

// File: rtl/platform_scroll_gen.sv
// -----------------------------------------------------------------------------
// platform_scroll_gen
// Produces the platform row window (plataform_start / plataform_end) used by
// VGA_Logic, on the 25 MHz pixel clock. An accepted scroll request moves the
// platform down by SCROLL_DIST rows, SCROLL_STEP rows per frame. All window
// and state updates happen on the vsync falling edge so a frame never shows
// a half-updated window.
//
// Ports:
//   clk     pixel clock (vga_clk)
//   reset   synchronous, active-high
//   freeze  (only with PLAT_FREEZE_EN) while high, frame ticks are ignored
//   bus     platform_scroll_gen_if.slave: vsync, scroll_req in;
//           scroll_ack, scrolling, plataform_start, plataform_end out
//
// Optional build macro: PLAT_FREEZE_EN adds the freeze input.
// -----------------------------------------------------------------------------
module platform_scroll_gen #(
  parameter int PLAT_START_INIT = 400,
  parameter int PLAT_THICK      = 16,
  parameter int SCROLL_STEP     = 2,
  parameter int SCROLL_DIST     = 96,
  parameter int V_VISIBLE       = 480
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef PLAT_FREEZE_EN
  input  logic                 freeze,
`endif
  platform_scroll_gen_if.slave bus
);

  localparam logic [9:0]  START_INIT = 10'(PLAT_START_INIT);
  localparam logic [9:0]  THICK_M1   = 10'(PLAT_THICK - 1);
  localparam logic [9:0]  END_INIT   = 10'(PLAT_START_INIT + PLAT_THICK - 1);
  localparam logic [9:0]  STEP       = 10'(SCROLL_STEP);
  localparam logic [9:0]  DIST       = 10'(SCROLL_DIST);
  localparam logic [10:0] VVIS       = 11'(V_VISIBLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t     state;
  logic       vsync_q;
  logic       pending;
  logic [9:0] remaining;
  logic [9:0] start_r;
  logic [9:0] end_r;
  logic       ack_r;
  logic       scrolling_r;

  logic       tick;
  logic       consume;
  logic       accept;
  logic [9:0] mv;
  logic [9:0] start_next;

  // Add with an 11-bit intermediate so the wrap compare sees the true sum.
  function automatic logic [9:0] wrap_add(input logic [9:0] base,
                                          input logic [9:0] delta);
    logic [10:0] sum;
    sum = {1'b0, base} + {1'b0, delta};
    if (sum >= VVIS) sum = sum - VVIS;
    return sum[9:0];
  endfunction

  always_comb begin
    tick = vsync_q & ~bus.vsync;
`ifdef PLAT_FREEZE_EN
    tick = tick & ~freeze;
`endif
    // Pending is consumed by a load in IDLE or SETTLE; a request on that
    // same cycle refills it, so a held request is re-accepted.
    consume    = tick & pending & (state != SCROLL);
    accept     = bus.scroll_req & (~pending | consume);
    mv         = (remaining < STEP) ? remaining : STEP;
    start_next = wrap_add(start_r, mv);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vsync_q     <= 1'b1;
      pending     <= 1'b0;
      remaining   <= '0;
      start_r     <= START_INIT;
      end_r       <= END_INIT;
      ack_r       <= 1'b0;
      scrolling_r <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      ack_r   <= accept;

      if (accept)       pending <= 1'b1;
      else if (consume) pending <= 1'b0;

      if (tick) begin
        unique case (state)
          IDLE: begin
            if (pending) begin
              remaining   <= DIST;
              state       <= SCROLL;
              scrolling_r <= 1'b1;
            end
          end
          SCROLL: begin
            start_r   <= start_next;
            // End row is left unwrapped; rows past the visible area are
            // simply never drawn.
            end_r     <= start_next + THICK_M1;
            remaining <= remaining - mv;
            if (remaining == mv) state <= SETTLE;
          end
          SETTLE: begin
            if (pending) begin
              remaining <= DIST;
              state     <= SCROLL;
            end else begin
              state       <= IDLE;
              scrolling_r <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            scrolling_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.scroll_ack      = ack_r;
  assign bus.scrolling       = scrolling_r;
  assign bus.plataform_start = start_r;
  assign bus.plataform_end   = end_r;

endmodule
